// File: rtl/game_round_controller.sv
// Referee for one playable round: countdown timer, lives, respawn freeze and win-hold delay.
// Emits registered one-cycle win/lose/respawn pulses toward the game state machine.
module game_round_controller #(
  parameter int FRAMES_PER_SEC  = 60,
  parameter int ROUND_SECONDS   = 120,
  parameter int START_LIVES     = 3,
  parameter int RESPAWN_FRAMES  = 90,
  parameter int WIN_HOLD_FRAMES = 30
) (
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [3:0] game_state,
  input  logic       goal_reached,
  input  logic       player_hit,
  output logic       win_the_game,
  output logic       lose_the_game,
  output logic       round_active,
  output logic       freeze_player,
  output logic       respawn,
  output logic [2:0] lives,
  output logic [7:0] time_left
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_DYING    = 3'd2,
    ST_WIN_HOLD = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [6:0] SEC_LAST     = 7'(FRAMES_PER_SEC - 1);
  localparam logic [7:0] RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);
  localparam logic [7:0] WIN_LAST     = 8'(WIN_HOLD_FRAMES - 1);
  localparam logic [2:0] LIVES_INIT   = 3'(START_LIVES);
  localparam logic [7:0] TIME_INIT    = 8'(ROUND_SECONDS);
  localparam logic [3:0] GS_PLAY      = 4'd2;

  state_t     state_r, state_s;
  logic [2:0] lives_r, lives_s;
  logic [7:0] time_r, time_s;
  logic [6:0] sec_r, sec_s;
  logic [7:0] hold_r, hold_s;
  logic       win_r, lose_r, respawn_r, active_r, freeze_r;
  logic       win_s, lose_s, respawn_s;
  logic [6:0] sec_run_s;
  logic [7:0] time_run_s;
  logic       expire_s;

  // Timer advance used by the states that let the clock run (RUN, DYING)
  always_comb begin
    sec_run_s  = sec_r;
    time_run_s = time_r;
    expire_s   = 1'b0;
    if (frame_tick) begin
      if (sec_r == SEC_LAST) begin
        sec_run_s = 7'd0;
        if (time_r != 8'd0) begin
          time_run_s = time_r - 8'd1;
          expire_s   = (time_r == 8'd1);
        end else begin
          time_run_s = 8'd0;
        end
      end else begin
        sec_run_s = sec_r + 7'd1;
      end
    end else begin
      sec_run_s = sec_r;
    end
  end

  // Next-state, counter and pulse decisions
  always_comb begin
    state_s   = state_r;
    lives_s   = lives_r;
    time_s    = time_r;
    sec_s     = sec_r;
    hold_s    = hold_r;
    win_s     = 1'b0;
    lose_s    = 1'b0;
    respawn_s = 1'b0;
    if (game_state != GS_PLAY) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_RUN;
          lives_s = LIVES_INIT;
          time_s  = TIME_INIT;
          sec_s   = 7'd0;
          hold_s  = 8'd0;
        end
        ST_RUN: begin
          sec_s  = sec_run_s;
          time_s = time_run_s;
          if (goal_reached) begin
            state_s = ST_WIN_HOLD;
            hold_s  = 8'd0;
          end else if (expire_s) begin
            state_s = ST_DONE;
            lose_s  = 1'b1;
          end else if (player_hit) begin
            if (lives_r <= 3'd1) begin
              lives_s = 3'd0;
              state_s = ST_DONE;
              lose_s  = 1'b1;
            end else begin
              lives_s = lives_r - 3'd1;
              state_s = ST_DYING;
              hold_s  = 8'd0;
            end
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_DYING: begin
          sec_s  = sec_run_s;
          time_s = time_run_s;
          // Running out of time while frozen ends the round without a respawn
          if (expire_s) begin
            state_s = ST_DONE;
            lose_s  = 1'b1;
          end else if (frame_tick) begin
            if (hold_r == RESPAWN_LAST) begin
              state_s   = ST_RUN;
              respawn_s = 1'b1;
            end else begin
              hold_s = hold_r + 8'd1;
            end
          end else begin
            state_s = ST_DYING;
          end
        end
        ST_WIN_HOLD: begin
          if (frame_tick) begin
            if (hold_r == WIN_LAST) begin
              state_s = ST_DONE;
              win_s   = 1'b1;
            end else begin
              hold_s = hold_r + 8'd1;
            end
          end else begin
            state_s = ST_WIN_HOLD;
          end
        end
        ST_DONE: begin
          state_s = ST_DONE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      lives_r   <= LIVES_INIT;
      time_r    <= TIME_INIT;
      sec_r     <= 7'd0;
      hold_r    <= 8'd0;
      win_r     <= 1'b0;
      lose_r    <= 1'b0;
      respawn_r <= 1'b0;
      active_r  <= 1'b0;
      freeze_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      lives_r   <= lives_s;
      time_r    <= time_s;
      sec_r     <= sec_s;
      hold_r    <= hold_s;
      win_r     <= win_s;
      lose_r    <= lose_s;
      respawn_r <= respawn_s;
      active_r  <= (state_s == ST_RUN) || (state_s == ST_DYING) || (state_s == ST_WIN_HOLD);
      freeze_r  <= (state_s == ST_DYING) || (state_s == ST_WIN_HOLD) || (state_s == ST_DONE);
    end
  end

  assign win_the_game  = win_r;
  assign lose_the_game = lose_r;
  assign respawn       = respawn_r;
  assign round_active  = active_r;
  assign freeze_player = freeze_r;
  assign lives         = lives_r;
  assign time_left     = time_r;

endmodule

// File: tb/tb_game_round_controller.sv
// Bench for game_round_controller: directed round scenarios followed by random play,
// all checked against a countdown-style reference model of the round rules.
module tb_game_round_controller;
  localparam int FPS = 4;
  localparam int RS  = 3;
  localparam int SL  = 2;
  localparam int RF  = 2;
  localparam int WH  = 2;

  logic       pixel_clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [3:0] game_state = 4'd0;
  logic       goal_reached = 1'b0;
  logic       player_hit = 1'b0;
  logic       win_the_game, lose_the_game, round_active, freeze_player, respawn;
  logic [2:0] lives;
  logic [7:0] time_left;

  game_round_controller #(
    .FRAMES_PER_SEC(FPS), .ROUND_SECONDS(RS), .START_LIVES(SL),
    .RESPAWN_FRAMES(RF), .WIN_HOLD_FRAMES(WH)
  ) dut (
    .pixel_clk(pixel_clk), .reset(reset), .frame_tick(frame_tick),
    .game_state(game_state), .goal_reached(goal_reached), .player_hit(player_hit),
    .win_the_game(win_the_game), .lose_the_game(lose_the_game),
    .round_active(round_active), .freeze_player(freeze_player), .respawn(respawn),
    .lives(lives), .time_left(time_left)
  );

  always #5 pixel_clk = ~pixel_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: round phase plus countdowns of frames remaining
  localparam int M_IDLE = 0, M_PLAY = 1, M_FROZEN = 2, M_WAIT_WIN = 3, M_OVER = 4;
  int m_mode = M_IDLE;
  int m_lives = SL;
  int m_time = RS;
  int m_frames_left = FPS;
  int m_wait_left = 0;
  int e_win = 0, e_lose = 0, e_resp = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input int gs, input bit tick, input bit goal, input bit hit);
    bit expired;
    e_win = 0; e_lose = 0; e_resp = 0; expired = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_lives = SL; m_time = RS; m_frames_left = FPS; m_wait_left = 0;
    end else if (gs != 2) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_PLAY; m_lives = SL; m_time = RS; m_frames_left = FPS;
    end else if (m_mode == M_PLAY || m_mode == M_FROZEN) begin
      if (tick) begin
        m_frames_left--;
        if (m_frames_left == 0) begin
          m_frames_left = FPS;
          if (m_time > 0) begin
            m_time--;
            expired = (m_time == 0);
          end
        end
      end
      if (m_mode == M_PLAY) begin
        if (goal) begin
          m_mode = M_WAIT_WIN; m_wait_left = WH;
        end else if (expired) begin
          m_mode = M_OVER; e_lose = 1;
        end else if (hit) begin
          if (m_lives == 1) begin
            m_lives = 0; m_mode = M_OVER; e_lose = 1;
          end else begin
            m_lives--; m_mode = M_FROZEN; m_wait_left = RF;
          end
        end
      end else if (expired) begin
        m_mode = M_OVER; e_lose = 1;
      end else if (tick) begin
        m_wait_left--;
        if (m_wait_left == 0) begin
          m_mode = M_PLAY; e_resp = 1;
        end
      end
    end else if (m_mode == M_WAIT_WIN) begin
      if (tick) begin
        m_wait_left--;
        if (m_wait_left == 0) begin
          m_mode = M_OVER; e_win = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("win", 8'(win_the_game), 8'(e_win));
    chk("lose", 8'(lose_the_game), 8'(e_lose));
    chk("respawn", 8'(respawn), 8'(e_resp));
    chk("round_active", 8'(round_active),
        8'(m_mode == M_PLAY || m_mode == M_FROZEN || m_mode == M_WAIT_WIN));
    chk("freeze", 8'(freeze_player),
        8'(m_mode == M_FROZEN || m_mode == M_WAIT_WIN || m_mode == M_OVER));
    chk("lives", 8'(lives), 8'(m_lives));
    chk("time_left", time_left, 8'(m_time));
  endtask

  task automatic cyc(input bit rst, input int gs, input bit tick, input bit goal, input bit hit);
    reset = rst; game_state = 4'(gs); frame_tick = tick; goal_reached = goal; player_hit = hit;
    model_step(rst, gs, tick, goal, hit);
    @(posedge pixel_clk);
    #1;
    check_all();
  endtask

  initial begin
    // Reset values
    cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk("rst_lives", 8'(lives), 8'd2);
    chk("rst_time", time_left, 8'd3);
    chk("rst_active", 8'(round_active), 8'd0);
    chk("rst_freeze", 8'(freeze_player), 8'd0);

    // Timeout: 12 ticks exhaust 3 seconds
    cyc(1'b0, 2, 1'b0, 1'b0, 1'b0);
    chk("to_run", 8'(round_active), 8'd1);
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b0, 2, 1'b1, 1'b0, 1'b0);
      if (i == 4) chk("to_t2", time_left, 8'd2);
      if (i == 8) chk("to_t1", time_left, 8'd1);
      if (i < 12) begin
        chk("to_no_lose", 8'(lose_the_game), 8'd0);
        cyc(1'b0, 2, 1'b0, 1'b0, 1'b0);
      end
    end
    chk("to_lose", 8'(lose_the_game), 8'd1);
    chk("to_t0", time_left, 8'd0);
    chk("to_lives", 8'(lives), 8'd2);
    chk("to_done_active", 8'(round_active), 8'd0);
    chk("to_done_freeze", 8'(freeze_player), 8'd1);
    cyc(1'b0, 2, 1'b0, 1'b0, 1'b0);
    chk("to_lose_once", 8'(lose_the_game), 8'd0);

    // Back to IDLE, reload on the next round
    cyc(1'b0, 1, 1'b0, 1'b0, 1'b0);
    chk("idle_active", 8'(round_active), 8'd0);
    cyc(1'b0, 2, 1'b0, 1'b0, 1'b0);
    chk("reload_time", time_left, 8'd3);
    chk("reload_lives", 8'(lives), 8'd2);

    // Respawn then fatal second hit
    cyc(1'b0, 2, 1'b0, 1'b0, 1'b1);
    chk("rs_lives", 8'(lives), 8'd1);
    chk("rs_freeze", 8'(freeze_player), 8'd1);
    cyc(1'b0, 2, 1'b1, 1'b0, 1'b0);
    chk("rs_early", 8'(respawn), 8'd0);
    cyc(1'b0, 2, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2, 1'b1, 1'b0, 1'b0);
    chk("rs_pulse", 8'(respawn), 8'd1);
    chk("rs_unfreeze", 8'(freeze_player), 8'd0);
    cyc(1'b0, 2, 1'b0, 1'b0, 1'b0);
    chk("rs_once", 8'(respawn), 8'd0);
    cyc(1'b0, 2, 1'b0, 1'b0, 1'b1);
    chk("rs_dead_lives", 8'(lives), 8'd0);
    chk("rs_dead_lose", 8'(lose_the_game), 8'd1);
    chk("rs_dead_norsp", 8'(respawn), 8'd0);
    cyc(1'b0, 2, 1'b0, 1'b0, 1'b0);

    // Win with goal held and hits during the hold
    cyc(1'b0, 1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2, 1'b0, 1'b1, 1'b0);
    chk("win_freeze", 8'(freeze_player), 8'd1);
    cyc(1'b0, 2, 1'b1, 1'b1, 1'b0);
    chk("win_early", 8'(win_the_game), 8'd0);
    cyc(1'b0, 2, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 2, 1'b1, 1'b1, 1'b1);
    chk("win_pulse", 8'(win_the_game), 8'd1);
    chk("win_nolose", 8'(lose_the_game), 8'd0);
    chk("win_time", time_left, 8'd3);
    cyc(1'b0, 2, 1'b0, 1'b1, 1'b1);
    chk("win_once", 8'(win_the_game), 8'd0);

    // Goal and hit together on the last life
    cyc(1'b0, 1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 2, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 2, 1'b1, 1'b0, 1'b0);
    chk("sim_respawn", 8'(respawn), 8'd1);
    cyc(1'b0, 2, 1'b0, 1'b1, 1'b1);
    chk("sim_lives", 8'(lives), 8'd1);
    chk("sim_nolose", 8'(lose_the_game), 8'd0);
    cyc(1'b0, 2, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 2, 1'b1, 1'b1, 1'b1);
    chk("sim_win", 8'(win_the_game), 8'd1);

    // Abort from DYING
    cyc(1'b0, 1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1, 1'b1, 1'b0, 1'b0);
    chk("ab_active", 8'(round_active), 8'd0);
    chk("ab_freeze", 8'(freeze_player), 8'd0);
    chk("ab_norsp", 8'(respawn), 8'd0);
    cyc(1'b0, 2, 1'b0, 1'b0, 1'b0);
    chk("ab_lives", 8'(lives), 8'd2);
    chk("ab_time", time_left, 8'd3);

    // Reset during WIN_HOLD
    cyc(1'b0, 2, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 2, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 2, 1'b1, 1'b1, 1'b0);
    chk("rw_nowin", 8'(win_the_game), 8'd0);
    chk("rw_active", 8'(round_active), 8'd0);
    chk("rw_freeze", 8'(freeze_player), 8'd0);
    cyc(1'b0, 2, 1'b1, 1'b1, 1'b0);
    chk("rw_nowin2", 8'(win_the_game), 8'd0);

    // Random play against the model
    for (int n = 0; n < 3000; n++) begin
      bit r_rst, r_tick, r_goal, r_hit;
      int r_gs;
      r_rst  = ($urandom_range(0, 199) == 0);
      r_gs   = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 15)) : 2;
      r_tick = ($urandom_range(0, 2) == 0);
      r_goal = ($urandom_range(0, 29) == 0);
      r_hit  = ($urandom_range(0, 9) == 0);
      cyc(r_rst, r_gs, r_tick, r_goal, r_hit);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/game_round_controller.md
Name: game_round_controller

Overview:
- Referees one playable round while the top-level game state machine reports game_state == 2 (in play).
- Owns the per-round countdown timer, the lives counter, the respawn freeze and the win-hold delay.
- Produces the one-cycle win_the_game / lose_the_game pulses consumed by the game state machine.
- Sits between the state machine, the VGA frame timing (frame_tick) and the player/collision logic.

Parameters:
- FRAMES_PER_SEC, 60, frame_ticks per timer second (2..127).
- ROUND_SECONDS, 120, timer start value (1..255).
- START_LIVES, 3, lives loaded at round start (1..7).
- RESPAWN_FRAMES, 90, frames the player is frozen after a non-fatal hit (1..255).
- WIN_HOLD_FRAMES, 30, frames between goal contact and the win pulse (1..255).

Ports:
- pixel_clk  in  1  clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse at vsync start
- game_state  in  4  from game state machine; 2 = in play
- goal_reached  in  1  level-sensitive; player overlaps goal
- player_hit  in  1  level-sensitive; player overlaps hazard
- win_the_game  out  1  one-cycle pulse
- lose_the_game  out  1  one-cycle pulse
- round_active  out  1  high in RUN, DYING and WIN_HOLD
- freeze_player  out  1  high in DYING, WIN_HOLD and DONE
- respawn  out  1  one-cycle pulse at DYING exit
- lives  out  3  remaining lives
- time_left  out  8  remaining seconds

Behaviour:
- Clock is pixel_clk. Reset is synchronous and active-high.
- Reset values: state = IDLE; lives = START_LIVES; time_left = ROUND_SECONDS; frame counter = 0; all pulse outputs and levels = 0.
- States: IDLE, RUN, DYING, WIN_HOLD, DONE.
- Global override: in any state, if game_state != 2, next state is IDLE with no pulses. This is the abort path.
- IDLE, when game_state == 2: next state RUN. Load lives = START_LIVES, time_left = ROUND_SECONDS, sec_cnt = 0, hold_cnt = 0.
- Timer, active in RUN and DYING:
  - On each frame_tick, sec_cnt increments.
  - When sec_cnt == FRAMES_PER_SEC-1 and frame_tick is high: sec_cnt becomes 0 and time_left decrements, saturating at 0.
  - If the decrement takes time_left from 1 to 0: lose_the_game = 1 on the next cycle, and state goes to DONE.
- RUN, priority per cycle, highest first:
  1. goal_reached: go to WIN_HOLD, hold_cnt = 0.
  2. Timer expiry: lose.
  3. player_hit with lives == 1: lives = 0, lose.
  4. player_hit with lives > 1: lives decrements, go to DYING, hold_cnt = 0.
- DYING:
  - player_hit and goal_reached are ignored.
  - hold_cnt increments on frame_tick.
  - On the frame_tick where hold_cnt == RESPAWN_FRAMES-1: respawn = 1 for one cycle, next state RUN.
  - Timer expiry inside DYING: lose, with no respawn pulse.
- WIN_HOLD:
  - Timer is frozen, and hits and timer expiry are ignored.
  - hold_cnt counts frame_ticks.
  - On the frame_tick where hold_cnt == WIN_HOLD_FRAMES-1: win_the_game = 1 for one cycle, next state DONE.
- DONE: all counters hold, no further pulses. Stays in DONE until game_state != 2, then goes to IDLE.
- Pulses are registered: asserted exactly one cycle, the cycle after the triggering edge condition. Never more than one of win/lose/respawn in the same cycle.
- lives and time_left hold their last values in IDLE and DONE, for HUD display. They reload only on the IDLE->RUN transition.
- Level inputs held high (goal_reached, player_hit) do not retrigger: DYING and WIN_HOLD ignore them. After a respawn, a still-high player_hit in RUN counts as a new hit. This is intended: the player must leave the hazard during the freeze.
- Reset mid-round: next cycle reproduces the reset values with no pulse emitted.
- frame_tick coincident with a state change: the tick is counted by the state being left, not the state being entered.

Test Plan:
Bench parameters: FRAMES_PER_SEC=4, ROUND_SECONDS=3, START_LIVES=2, RESPAWN_FRAMES=2, WIN_HOLD_FRAMES=2.
- Timeout: game_state=2 with no hits or goal, 12 frame_ticks -> time_left steps 3,2,1,0; a single lose_the_game pulse one cycle after the 12th tick; lives stays 2; state DONE.
- Respawn: one-cycle player_hit in RUN -> lives=1, freeze_player=1; respawn pulse one cycle after the 2nd following frame_tick; freeze_player=0; a 2nd hit -> lives=0 and lose_the_game pulse with no respawn.
- Win: goal_reached held high -> freeze_player=1, time_left frozen; win_the_game pulse after 2 frame_ticks; no lose pulse even if player_hit asserts during WIN_HOLD.
- Simultaneous: goal_reached and player_hit (lives=1) in the same cycle -> WIN_HOLD, lives stays 1, eventual win pulse only.
- Abort: game_state changes 2->1 while in DYING -> IDLE next cycle, no pulses. Return to 2 -> lives=2, time_left=3 reloaded.
- Reset during WIN_HOLD -> all outputs at reset values the next cycle; win_the_game never asserted.
